// File: rtl/color_pkg.sv
// Shared pixel type and controller state encoding for the frame-swap datapath.
package color_pkg;

  typedef logic [11:0] color12_t;

  typedef enum logic [1:0] {
    StClear,
    StRender,
    StWaitVsync,
    StSwap
  } fsm_state_e;

  localparam logic [7:0] MissedMax = 8'hFF;

endpackage

// File: rtl/fb_raster_counter.sv
// Raster-order (x fastest) pixel counter used to sweep the back buffer during clear.
module fb_raster_counter #(
  parameter int unsigned FB_WIDTH  = 160,
  parameter int unsigned FB_HEIGHT = 120
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  output logic [$clog2(FB_WIDTH)-1:0]  x,
  output logic [$clog2(FB_HEIGHT)-1:0] y,
  output logic                         last
);

  localparam int unsigned XW = $clog2(FB_WIDTH);
  localparam int unsigned YW = $clog2(FB_HEIGHT);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_end;

  assign x_end = (x_q == XW'(FB_WIDTH - 1));
  assign last  = x_end && (y_q == YW'(FB_HEIGHT - 1));
  assign x     = x_q;
  assign y     = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    // Wrapping on the last pixel leaves the counter ready for the next sweep.
    if (clr || (en && last)) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/frame_swap_ctrl.sv
// Double-buffer sequencer: clears the back buffer, passes renderer writes through,
// then swaps buffers on the first vsync after the renderer finishes a frame.
module frame_swap_ctrl
  import color_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = 160,
  parameter int unsigned FB_HEIGHT = 120,
  parameter bit          CLEAR_EN  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  color12_t                     clear_color,
  input  logic                         vsync_pulse,
  input  logic                         render_done,
  input  logic                         rend_we,
  input  logic [$clog2(FB_WIDTH)-1:0]  rend_x,
  input  logic [$clog2(FB_HEIGHT)-1:0] rend_y,
  input  color12_t                     rend_data,
  output logic                         rend_ready,
  output logic                         fb_we,
  output logic [$clog2(FB_WIDTH)-1:0]  fb_x,
  output logic [$clog2(FB_HEIGHT)-1:0] fb_y,
  output color12_t                     fb_data,
  output logic                         swap,
  output logic [15:0]                  frame_count,
  output logic [7:0]                   missed_vsync,
  output logic                         drop_err
);

  localparam int unsigned XW = $clog2(FB_WIDTH);
  localparam int unsigned YW = $clog2(FB_HEIGHT);

  fsm_state_e    state_q, state_d;
  logic          run_q;
  logic          fb_we_q, fb_we_d;
  logic [XW-1:0] fb_x_q, fb_x_d;
  logic [YW-1:0] fb_y_q, fb_y_d;
  color12_t      fb_data_q, fb_data_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [7:0]    missed_q, missed_d;
  logic          drop_q, drop_d;

  logic [XW-1:0] ras_x;
  logic [YW-1:0] ras_y;
  logic          ras_last;
  logic          clearing;

  // run_q delays all activity by one cycle after reset so the first clear write
  // lands on the second edge (state register, then output register).
  assign clearing   = (state_q == StClear) && run_q;
  assign rend_ready = (state_q == StRender) && run_q;
  assign swap       = (state_q == StSwap);

  fb_raster_counter #(
    .FB_WIDTH (FB_WIDTH),
    .FB_HEIGHT(FB_HEIGHT)
  ) u_raster (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q != StClear),
    .en   (clearing),
    .x    (ras_x),
    .y    (ras_y),
    .last (ras_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear:     if (clearing && ras_last) state_d = StRender;
      StRender:    if (rend_ready && render_done) state_d = StWaitVsync;
      StWaitVsync: if (vsync_pulse) state_d = StSwap;
      StSwap:      state_d = CLEAR_EN ? StClear : StRender;
      default:     state_d = StClear;
    endcase
  end

  always_comb begin
    fb_we_d       = 1'b0;
    fb_x_d        = fb_x_q;
    fb_y_d        = fb_y_q;
    fb_data_d     = fb_data_q;
    frame_count_d = frame_count_q + {15'd0, swap};
    missed_d      = missed_q;
    drop_d        = drop_q | (rend_we & ~rend_ready);
    if (clearing) begin
      fb_we_d   = 1'b1;
      fb_x_d    = ras_x;
      fb_y_d    = ras_y;
      fb_data_d = clear_color;
    end else if (rend_ready && rend_we) begin
      fb_we_d   = 1'b1;
      fb_x_d    = rend_x;
      fb_y_d    = rend_y;
      fb_data_d = rend_data;
    end
    if ((state_q == StRender) && vsync_pulse && (missed_q != MissedMax)) begin
      missed_d = missed_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CLEAR_EN ? StClear : StRender;
      run_q         <= 1'b0;
      fb_we_q       <= 1'b0;
      fb_x_q        <= '0;
      fb_y_q        <= '0;
      fb_data_q     <= '0;
      frame_count_q <= '0;
      missed_q      <= '0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= 1'b1;
      fb_we_q       <= fb_we_d;
      fb_x_q        <= fb_x_d;
      fb_y_q        <= fb_y_d;
      fb_data_q     <= fb_data_d;
      frame_count_q <= frame_count_d;
      missed_q      <= missed_d;
      drop_q        <= drop_d;
    end
  end

  assign fb_we        = fb_we_q;
  assign fb_x         = fb_x_q;
  assign fb_y         = fb_y_q;
  assign fb_data      = fb_data_q;
  assign frame_count  = frame_count_q;
  assign missed_vsync = missed_q;
  assign drop_err     = drop_q;

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Randomized bench for frame_swap_ctrl against a pixel-index based reference model.
module tb_frame_swap_ctrl;
  import color_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned XW = $clog2(W);
  localparam int unsigned YW = $clog2(H);

  localparam int MClear  = 0;
  localparam int MRender = 1;
  localparam int MWait   = 2;
  localparam int MSwap   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  color12_t      clear_color = '0;
  logic          vsync_pulse = 1'b0;
  logic          render_done = 1'b0;
  logic          rend_we     = 1'b0;
  logic [XW-1:0] rend_x      = '0;
  logic [YW-1:0] rend_y      = '0;
  color12_t      rend_data   = '0;
  logic          rend_ready, fb_we, swap, drop_err;
  logic [XW-1:0] fb_x;
  logic [YW-1:0] fb_y;
  color12_t      fb_data;
  logic [15:0]   frame_count;
  logic [7:0]    missed_vsync;

  logic          nc_vsync = 1'b0;
  logic          nc_done  = 1'b0;
  logic          nc_ready, nc_fb_we, nc_swap, nc_drop;
  logic [XW-1:0] nc_fb_x;
  logic [YW-1:0] nc_fb_y;
  color12_t      nc_fb_data;
  logic [15:0]   nc_fc;
  logic [7:0]    nc_missed;

  frame_swap_ctrl #(.FB_WIDTH(W), .FB_HEIGHT(H), .CLEAR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clear_color(clear_color), .vsync_pulse(vsync_pulse),
    .render_done(render_done), .rend_we(rend_we), .rend_x(rend_x), .rend_y(rend_y),
    .rend_data(rend_data), .rend_ready(rend_ready), .fb_we(fb_we), .fb_x(fb_x),
    .fb_y(fb_y), .fb_data(fb_data), .swap(swap), .frame_count(frame_count),
    .missed_vsync(missed_vsync), .drop_err(drop_err)
  );

  frame_swap_ctrl #(.FB_WIDTH(W), .FB_HEIGHT(H), .CLEAR_EN(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .clear_color(12'hABC), .vsync_pulse(nc_vsync),
    .render_done(nc_done), .rend_we(1'b0), .rend_x('0), .rend_y('0),
    .rend_data(12'h000), .rend_ready(nc_ready), .fb_we(nc_fb_we), .fb_x(nc_fb_x),
    .fb_y(nc_fb_y), .fb_data(nc_fb_data), .swap(nc_swap), .frame_count(nc_fc),
    .missed_vsync(nc_missed), .drop_err(nc_drop)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode plus a linear clear pixel index, outputs as seen after the edge.
  int       m_mode, m_idx;
  bit       m_started;
  bit       e_we, e_drop;
  int       e_x, e_y, e_missed, e_fc;
  color12_t e_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_mode    = MClear;
    m_idx     = 0;
    m_started = 1'b0;
    e_we      = 1'b0;
    e_x       = 0;
    e_y       = 0;
    e_data    = '0;
    e_drop    = 1'b0;
    e_missed  = 0;
    e_fc      = 0;
  endtask

  task automatic check_outputs();
    check_eq("fb_we", fb_we, e_we);
    if (e_we) begin
      check_eq("fb_x", fb_x, e_x);
      check_eq("fb_y", fb_y, e_y);
      check_eq("fb_data", fb_data, e_data);
    end
    check_eq("rend_ready", rend_ready, (m_mode == MRender) && m_started);
    check_eq("swap", swap, m_mode == MSwap);
    check_eq("frame_count", frame_count, e_fc);
    check_eq("missed_vsync", missed_vsync, e_missed);
    check_eq("drop_err", drop_err, e_drop);
  endtask

  // Applies one cycle of stimulus at a falling edge, advances the model, checks next fall.
  task automatic step(input bit we, input bit done, input bit vs);
    bit ready;
    clear_color = 12'($urandom);
    rend_x      = XW'($urandom_range(W - 1, 0));
    rend_y      = YW'($urandom_range(H - 1, 0));
    rend_data   = 12'($urandom);
    rend_we     = we;
    render_done = done;
    vsync_pulse = vs;
    ready = (m_mode == MRender) && m_started;
    if (m_mode == MClear && m_started) begin
      e_we   = 1'b1;
      e_x    = m_idx % W;
      e_y    = m_idx / W;
      e_data = clear_color;
    end else if (ready && we) begin
      e_we   = 1'b1;
      e_x    = rend_x;
      e_y    = rend_y;
      e_data = rend_data;
    end else begin
      e_we = 1'b0;
    end
    if (we && !ready) e_drop = 1'b1;
    if (m_mode == MRender && vs && e_missed < 255) e_missed++;
    if (m_mode == MSwap) e_fc = (e_fc + 1) % 65536;
    case (m_mode)
      MClear: if (m_started) begin
        m_idx++;
        if (m_idx == W * H) begin
          m_idx  = 0;
          m_mode = MRender;
        end
      end
      MRender: if (ready && done) m_mode = MWait;
      MWait:   if (vs) m_mode = MSwap;
      default: begin
        m_mode = MClear;
        m_idx  = 0;
      end
    endcase
    m_started = 1'b1;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    rend_we     = 1'b0;
    render_done = 1'b0;
    vsync_pulse = 1'b0;
    nc_done     = 1'b0;
    nc_vsync    = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_eq("rst_fb_x", fb_x, 0);
    check_eq("rst_fb_y", fb_y, 0);
    check_eq("rst_fb_data", fb_data, 0);
    check_eq("rst_nc_ready", nc_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_render();
    for (int i = 0; i < 100 && m_mode != MRender; i++) step(1'b0, 1'b0, $urandom_range(3, 0) == 0);
    check_eq("reach_render", rend_ready, 1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    repeat (16) step(1'b0, 1'b0, 1'b0);
    check_eq("ready_after_clear", rend_ready, 1);

    // Well-behaved renderer: writes only while ready.
    repeat (400) begin
      bit rdy;
      rdy = (m_mode == MRender) && m_started;
      step(rdy && $urandom_range(1, 0) == 1, $urandom_range(15, 0) == 0,
           $urandom_range(7, 0) == 0);
    end
    check_eq("no_drop_yet", drop_err, 0);

    // render_done and vsync together must not swap; the following vsync does.
    wait_render();
    step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check_eq("no_swap_same_cycle", swap, 0);
    step(1'b0, 1'b0, 1'b1);
    check_eq("swap_next_vsync", swap, 1);
    step(1'b0, 1'b0, 1'b0);

    // Saturate the missed-vsync counter.
    wait_render();
    repeat (300) step(1'b0, 1'b0, 1'b1);
    check_eq("missed_sat", missed_vsync, 255);
    step(1'b0, 1'b1, 1'b0);

    // Unrestricted renderer writes, including while not ready.
    repeat (300) step($urandom_range(1, 0) == 1, $urandom_range(15, 0) == 0,
                      $urandom_range(5, 0) == 0);
    check_eq("drop_sticky", drop_err, 1);

    // Abort a clear at pixel 6, then the sweep restarts from (0,0).
    for (int i = 0; i < 200 && !(m_mode == MClear && m_started && m_idx == 6); i++)
      step(1'b0, m_mode == MRender, $urandom_range(3, 0) == 0);
    check_eq("at_px6", fb_y * W + fb_x, 5);
    do_reset();
    repeat (20) step(1'b0, 1'b0, 1'b0);

    // CLEAR_EN=0 instance: swap goes straight back to render with no writes.
    check_eq("nc_ready", nc_ready, 1);
    nc_done = 1'b1;
    @(negedge clk);
    nc_done = 1'b0;
    check_eq("nc_wait_ready", nc_ready, 0);
    check_eq("nc_wait_swap", nc_swap, 0);
    nc_vsync = 1'b1;
    @(negedge clk);
    nc_vsync = 1'b0;
    check_eq("nc_swap", nc_swap, 1);
    check_eq("nc_swap_we", nc_fb_we, 0);
    @(negedge clk);
    check_eq("nc_ready_after", nc_ready, 1);
    check_eq("nc_we_after", nc_fb_we, 0);
    check_eq("nc_swap_after", nc_swap, 0);
    check_eq("nc_fc", nc_fc, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
